sqrt_seq_ctrl: RTL and testbench

SQRT_SEQ_CTRL -- requirements
Module: sqrt_seq_ctrl

---
 rtl/sqrt_seq_ctrl_if.sv | 27 ++
 rtl/sqrt_seq_ctrl.sv | 118 +++++++++++
 tb/tb_sqrt_seq_ctrl.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sqrt_seq_ctrl_if.sv
// Request/result handshake and arithmetic-unit bus for the sequential
// square-root controller. The controller takes the slave view: it receives
// start/radicand and the AU result, and drives status, results and AU operands.
interface sqrt_seq_ctrl_if #(
  parameter int W = 8
);
  logic             start;
  logic [W-1:0]     radicand;
  logic             busy;
  logic             done;
  logic [W/2-1:0]   root;
  logic [W/2:0]     rem;
  logic [W-1:0]     au_a;
  logic [W-1:0]     au_b;
  logic [1:0]       au_sel;
  logic [W-1:0]     au_out;

  modport master (
    output start, radicand, au_out,
    input  busy, done, root, rem, au_a, au_b, au_sel
  );

  modport slave (
    input  start, radicand, au_out,
    output busy, done, root, rem, au_a, au_b, au_sel
  );
endinterface

// File: rtl/sqrt_seq_ctrl.sv
// Sequential integer square root by odd-number subtraction. Every add and
// subtract is issued to an external 1-cycle-latency arithmetic unit; the only
// local arithmetic is the root counter increment and the underflow compare.
module sqrt_seq_ctrl #(
  parameter int W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  sqrt_seq_ctrl_if.slave bus
);
  localparam int OW = W / 2 + 1;  // odd-number register width
  localparam int RW = W / 2;      // root width

  localparam logic [1:0] SEL_ADD = 2'b00;
  localparam logic [1:0] SEL_SUB = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    SUB,
    SUB_CHK,
    ADD_CHK,
    DONE
  } state_t;

  state_t          state_reg, state_next;
  logic [W-1:0]    r_reg, r_next;
  logic [OW-1:0]   o_reg, o_next;
  logic [RW-1:0]   cnt_reg, cnt_next;
  logic [RW-1:0]   root_reg, root_next;
  logic [OW-1:0]   rem_reg, rem_next;
  logic [W-1:0]    au_a_c, au_b_c;
  logic [1:0]      au_sel_c;
  logic            underflow;

  // A wrapped subtract result is larger than the minuend it came from.
  assign underflow = (bus.au_out > r_reg);

  // State, working registers and held results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      r_reg     <= '0;
      o_reg     <= '0;
      cnt_reg   <= '0;
      root_reg  <= '0;
      rem_reg   <= '0;
    end else begin
      state_reg <= state_next;
      r_reg     <= r_next;
      o_reg     <= o_next;
      cnt_reg   <= cnt_next;
      root_reg  <= root_next;
      rem_reg   <= rem_next;
    end
  end

  // Next-state, working-register updates and AU operand/opcode drive.
  always_comb begin
    state_next = state_reg;
    r_next     = r_reg;
    o_next     = o_reg;
    cnt_next   = cnt_reg;
    root_next  = root_reg;
    rem_next   = rem_reg;
    au_a_c     = '0;
    au_b_c     = '0;
    au_sel_c   = SEL_ADD;
    unique case (state_reg)
      IDLE: begin
        if (bus.start) begin
          r_next     = bus.radicand;
          o_next     = OW'(1);
          cnt_next   = '0;
          state_next = SUB;
        end
      end
      SUB: begin
        au_a_c     = r_reg;
        au_b_c     = {{(W - OW){1'b0}}, o_reg};
        au_sel_c   = SEL_SUB;
        state_next = SUB_CHK;
      end
      SUB_CHK: begin
        if (underflow) begin
          // Results are loaded on the way into DONE so they appear with done.
          root_next  = cnt_reg;
          rem_next   = r_reg[OW-1:0];
          state_next = DONE;
        end else begin
          r_next     = bus.au_out;
          cnt_next   = cnt_reg + 1'b1;
          au_a_c     = {{(W - OW){1'b0}}, o_reg};
          au_b_c     = {{(W - 2){1'b0}}, 2'b10};
          au_sel_c   = SEL_ADD;
          state_next = ADD_CHK;
        end
      end
      ADD_CHK: begin
        o_next     = bus.au_out[OW-1:0];
        state_next = SUB;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.busy   = (state_reg != IDLE);
  assign bus.done   = (state_reg == DONE);
  assign bus.root   = root_reg;
  assign bus.rem    = rem_reg;
  assign bus.au_a   = au_a_c;
  assign bus.au_b   = au_b_c;
  assign bus.au_sel = au_sel_c;
endmodule

// File: tb/tb_sqrt_seq_ctrl.sv
// Directed bench for sqrt_seq_ctrl with a 1-cycle registered add/sub AU model.
// Latency is counted as the number of rising edges after the accepting edge
// up to and including the first edge that samples done high.
module tb_sqrt_seq_ctrl;
  localparam int W = 8;

  logic clk;
  logic rst_n;

  sqrt_seq_ctrl_if #(.W(W)) bus ();

  sqrt_seq_ctrl #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Arithmetic unit: registered add/sub, result one cycle after operands.
  always @(posedge clk) begin
    if (bus.au_sel == 2'b10) bus.au_out <= bus.au_a - bus.au_b;
    else                     bus.au_out <= bus.au_a + bus.au_b;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int sub_b_q[$];
  int last_sub_a = 0;
  int last_sub_b = 0;
  int add_nz     = 0;
  int idle_err   = 0;
  int hold_err   = 0;

  // Mid-cycle bus monitor: subtract operands, adds, and idle operand drive.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.au_sel == 2'b10) begin
        sub_b_q.push_back(int'(bus.au_b));
        last_sub_a = int'(bus.au_a);
        last_sub_b = int'(bus.au_b);
      end
      if (bus.au_sel == 2'b00 && (bus.au_a != 0 || bus.au_b != 0)) add_nz++;
      if ((!bus.busy || bus.done) && (bus.au_a != 0 || bus.au_b != 0 || bus.au_sel != 0))
        idle_err++;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int isqrt(input int x);
    int r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  // One computation: accept x, scramble radicand afterwards, wait for done.
  task automatic run_sqrt(input logic [7:0] x, output int root_o, output int rem_o,
                          output int lat_o);
    logic [3:0] hold_root;
    logic [4:0] hold_rem;
    root_o = -1;
    rem_o  = -1;
    lat_o  = -1;
    @(negedge clk);
    bus.radicand = x;
    bus.start    = 1'b1;
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.radicand = ~x;
    sub_b_q.delete();
    add_nz    = 0;
    hold_root = bus.root;
    hold_rem  = bus.rem;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (bus.done) begin
        lat_o  = c + 1;
        root_o = int'(bus.root);
        rem_o  = int'(bus.rem);
        break;
      end
      if (bus.root != hold_root || bus.rem != hold_rem) hold_err++;
    end
    check_val("done_seen", (lat_o != -1), 1);
    @(negedge clk);
  endtask

  initial begin
    int rt, rm, lt;
    int done_cnt, first_done;
    bus.start    = 1'b0;
    bus.radicand = '0;
    rst_n        = 1'b0;

    // Reset state
    #12;
    check_val("rst_busy", bus.busy, 0);
    check_val("rst_done", bus.done, 0);
    check_val("rst_root", bus.root, 0);
    check_val("rst_rem", bus.rem, 0);
    check_val("rst_au_a", bus.au_a, 0);
    check_val("rst_au_b", bus.au_b, 0);
    check_val("rst_au_sel", bus.au_sel, 0);
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset released");

    // radicand 0
    run_sqrt(8'd0, rt, rm, lt);
    $display("sqrt(0): root=%0d rem=%0d lat=%0d", rt, rm, lt);
    check_val("r0_lat", lt, 3);
    check_val("r0_root", rt, 0);
    check_val("r0_rem", rm, 0);
    check_val("r0_add_nz", add_nz, 0);
    check_val("r0_subs", sub_b_q.size(), 1);

    // radicand 16
    run_sqrt(8'd16, rt, rm, lt);
    $display("sqrt(16): root=%0d rem=%0d lat=%0d", rt, rm, lt);
    check_val("r16_lat", lt, 15);
    check_val("r16_root", rt, 4);
    check_val("r16_rem", rm, 0);
    check_val("r16_subs", sub_b_q.size(), 5);
    for (int i = 0; i < 5 && i < sub_b_q.size(); i++)
      check_val("r16_sub_b", sub_b_q[i], 2 * i + 1);
    check_val("r16_adds", add_nz, 4);

    // radicand 255
    run_sqrt(8'd255, rt, rm, lt);
    $display("sqrt(255): root=%0d rem=%0d lat=%0d", rt, rm, lt);
    check_val("r255_lat", lt, 48);
    check_val("r255_root", rt, 15);
    check_val("r255_rem", rm, 30);
    check_val("r255_subs", sub_b_q.size(), 16);
    check_val("r255_last_a", last_sub_a, 30);
    check_val("r255_last_b", last_sub_b, 31);

    // radicand 10 with start re-pulsed while busy and held through DONE
    @(negedge clk);
    bus.radicand = 8'd10;
    bus.start    = 1'b1;
    @(posedge clk);
    done_cnt   = 0;
    first_done = -1;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (c == 2 || c == 6) begin
        bus.start    = 1'b1;
        bus.radicand = 8'd77;
      end else if (c >= 8) begin
        bus.start    = 1'b1;
      end else begin
        bus.start    = 1'b0;
      end
      if (bus.done) begin
        done_cnt++;
        if (first_done < 0) begin
          first_done = c;
          check_val("r10_root", bus.root, 3);
          check_val("r10_rem", bus.rem, 1);
        end
      end
      if (c == 12) check_val("r10_idle_gap", bus.busy, 0);
      if (c == 13) check_val("r10_restart", bus.busy, 1);
    end
    bus.start = 1'b0;
    $display("sqrt(10) with re-pulsed start: dones=%0d first_done_cycle=%0d", done_cnt, first_done);
    check_val("r10_done_cnt", done_cnt, 1);
    check_val("r10_lat", first_done + 1, 12);
    lt = -1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (bus.done) begin
        lt = c;
        check_val("r77_root", bus.root, 8);
        check_val("r77_rem", bus.rem, 13);
        break;
      end
    end
    check_val("r77_done_seen", (lt != -1), 1);
    $display("sqrt(77) after held start: root=%0d rem=%0d", bus.root, bus.rem);
    @(negedge clk);

    // radicand 200 aborted by reset in cycle 5
    bus.radicand = 8'd200;
    bus.start    = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    done_cnt  = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_val("ar_busy", bus.busy, 0);
    check_val("ar_done", bus.done, 0);
    check_val("ar_root", bus.root, 0);
    check_val("ar_rem", bus.rem, 0);
    check_val("ar_au_a", bus.au_a, 0);
    check_val("ar_au_b", bus.au_b, 0);
    check_val("ar_au_sel", bus.au_sel, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    rst_n = 1'b1;
    check_val("ar_no_done", done_cnt, 0);
    $display("sqrt(200) aborted by reset: dones=%0d", done_cnt);
    run_sqrt(8'd99, rt, rm, lt);
    $display("sqrt(99): root=%0d rem=%0d lat=%0d", rt, rm, lt);
    check_val("r99_root", rt, 9);
    check_val("r99_rem", rm, 18);
    check_val("r99_lat", lt, 30);

    // Exhaustive sweep
    for (int x = 0; x < 256; x++) begin
      int er;
      er = isqrt(x);
      run_sqrt(8'(x), rt, rm, lt);
      $display("sweep sqrt(%0d): root=%0d rem=%0d lat=%0d", x, rt, rm, lt);
      check_val("sw_root", rt, er);
      check_val("sw_rem", rm, x - er * er);
      check_val("sw_rem_le", (rm <= 2 * rt), 1);
      check_val("sw_lat", lt, 3 * er + 3);
    end

    check_val("hold_err", hold_err, 0);
    check_val("idle_drive_err", idle_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
